// File: rtl/stopwatch_counter.sv
// stopwatch_counter: seconds-counting core of the stopwatch.
// Raw start/stop and clear buttons are synchronized and edge-detected and drive
// an IDLE/RUN/PAUSE state machine. A prescaler turns CLK_HZ cycles of run time
// into one count increment.
// Build option: define STOPWATCH_WRAP_EN to make the count wrap from MAX_COUNT
// back to 0 while running. Without it, reaching MAX_COUNT pauses and locks the
// counter until a clear.
module stopwatch_counter #(
    parameter int CLK_HZ    = 100_000_000,
    parameter int MAX_COUNT = 5999
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_start_stop,
    input  logic        btn_clear,
    output logic [12:0] count,
    output logic        running,
    output logic        tick
);

    localparam logic [26:0] PRESCALE_LAST = 27'(CLK_HZ - 1);
    localparam logic [12:0] COUNT_LAST    = 13'(MAX_COUNT);

`ifdef STOPWATCH_WRAP_EN
    localparam bit WRAP_EN = 1'b1;
`else
    localparam bit WRAP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    state_t      state;
    logic [26:0] prescaler;

    logic ss_s1, ss_s2, ss_p;
    logic clr_s1, clr_s2, clr_p;
    logic ss_rise, clr_rise;

    logic [12:0] count_inc;
    logic        at_max;
    logic        second_done;
    logic        reaches_max;

    // Two-flop synchronizers plus a previous-value flop for each button.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ss_s1  <= 1'b0;
            ss_s2  <= 1'b0;
            ss_p   <= 1'b0;
            clr_s1 <= 1'b0;
            clr_s2 <= 1'b0;
            clr_p  <= 1'b0;
        end else begin
            ss_s1  <= btn_start_stop;
            ss_s2  <= ss_s1;
            ss_p   <= ss_s2;
            clr_s1 <= btn_clear;
            clr_s2 <= clr_s1;
            clr_p  <= clr_s2;
        end
    end

    assign ss_rise  = ss_s2 & ~ss_p;
    assign clr_rise = clr_s2 & ~clr_p;

    assign count_inc   = count + 13'd1;
    assign at_max      = (count == COUNT_LAST);
    assign second_done = (prescaler == PRESCALE_LAST);
    assign reaches_max = (count_inc == COUNT_LAST);

    // Run/pause state machine with the prescaler, count and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            prescaler <= '0;
            count     <= '0;
            running   <= 1'b0;
            tick      <= 1'b0;
        end else begin
            tick <= 1'b0;
            if (clr_rise) begin
                state     <= IDLE;
                prescaler <= '0;
                count     <= '0;
                running   <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        prescaler <= '0;
                        count     <= '0;
                        if (ss_rise) begin
                            state   <= RUN;
                            running <= 1'b1;
                        end
                    end

                    RUN: begin
                        if (second_done) begin
                            prescaler <= '0;
                            if (WRAP_EN) begin
                                tick  <= 1'b1;
                                count <= at_max ? 13'd0 : count_inc;
                                if (ss_rise) begin
                                    state   <= PAUSE;
                                    running <= 1'b0;
                                end
                            end else begin
                                tick <= ~at_max;
                                if (!at_max) begin
                                    count <= count_inc;
                                end
                                if (ss_rise || at_max || reaches_max) begin
                                    state   <= PAUSE;
                                    running <= 1'b0;
                                end
                            end
                        end else begin
                            prescaler <= prescaler + 27'd1;
                            if (ss_rise) begin
                                state   <= PAUSE;
                                running <= 1'b0;
                            end
                        end
                    end

                    PAUSE: begin
                        if (ss_rise && (WRAP_EN || !at_max)) begin
                            state   <= RUN;
                            running <= 1'b1;
                        end
                    end

                    default: begin
                        state     <= IDLE;
                        prescaler <= '0;
                        count     <= '0;
                        running   <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
